seq_player: RTL and testbench

Pattern player that drives a step-driven sequence detector through its `in`/`next` interface and captures the detector's `out` response.

- Replays a parameterised bit pattern, one bit per emulated `next` button press, with programmable press and release widths.
- Samples the detector output once per step.
- Optionally compares the captured response against an expected pattern.
- Sits on the driving side of the sequence-detector port, as an on-chip self-test source in front of the FSM under test.

---
 rtl/seq_player.sv | 208 ++++++++++++++++++++
 tb/tb_seq_player.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_player.sv
// seq_player: replays PATTERN through a sequence detector's in/next port and captures its out per step.
// Define SEQ_PLAYER_CHECK_EN to compare each captured bit against EXPECT and report err_count/pass.
module seq_player #(
    parameter int             LEN      = 11,
    parameter logic [LEN-1:0] PATTERN  = 11'h31A,
    parameter logic [LEN-1:0] EXPECT   = '0,
    parameter int             HIGH_CYC = 4,
    parameter int             LOW_CYC  = 4,
    localparam int            W        = $clog2(LEN + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           out_fb,
    output logic           seq_in,
    output logic           seq_next,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   step_idx,
    output logic [LEN-1:0] captured,
    output logic [W-1:0]   err_count,
    output logic           pass
);

    localparam int CMAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYC - 1);
    localparam logic [W-1:0]  STEP_LAST = W'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           seq_in_q, seq_in_d;
    logic           seq_next_q, seq_next_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   step_idx_q, step_idx_d;
    logic [LEN-1:0] captured_q, captured_d;

    logic [W-1:0]   step_nxt;
    logic [LEN-1:0] pat_shift;
    logic [LEN-1:0] sample_mask;

`ifdef SEQ_PLAYER_CHECK_EN
    logic [W-1:0]   err_count_q, err_count_d;
    logic           pass_q, pass_d;
    logic [LEN-1:0] exp_shift;
    logic           mismatch;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seq_in_d    = seq_in_q;
        seq_next_d  = seq_next_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        step_idx_d  = step_idx_q;
        captured_d  = captured_q;
        step_nxt    = step_idx_q + W'(1);
        pat_shift   = PATTERN >> step_nxt;
        sample_mask = LEN'(1) << step_idx_q;
`ifdef SEQ_PLAYER_CHECK_EN
        err_count_d = err_count_q;
        pass_d      = pass_q;
        exp_shift   = EXPECT >> step_idx_q;
        mismatch    = out_fb ^ exp_shift[0];
`endif

        case (state_q)
            S_IDLE: begin
                seq_next_d = 1'b0;
                busy_d     = 1'b0;
                if (start && !abort) begin
                    state_d    = S_SETUP;
                    cnt_d      = '0;
                    step_idx_d = '0;
                    captured_d = '0;
                    seq_in_d   = PATTERN[0];
                    busy_d     = 1'b1;
`ifdef SEQ_PLAYER_CHECK_EN
                    err_count_d = '0;
                    pass_d      = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                state_d    = S_HIGH;
                seq_next_d = 1'b1;
                cnt_d      = '0;
            end
            S_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d    = S_LOW;
                    seq_next_d = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    // Sample point: the detector has had LOW_CYC cycles to settle after the release.
                    cnt_d      = '0;
                    captured_d = (captured_q & ~sample_mask) | (out_fb ? sample_mask : '0);
`ifdef SEQ_PLAYER_CHECK_EN
                    err_count_d = err_count_q + W'(mismatch);
`endif
                    if (step_idx_q == STEP_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`ifdef SEQ_PLAYER_CHECK_EN
                        pass_d = (err_count_d == '0);
`endif
                    end else begin
                        state_d    = S_SETUP;
                        step_idx_d = step_nxt;
                        seq_in_d   = pat_shift[0];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                seq_next_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase

        // A cancel freezes the partial results exactly as they stood before this edge.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            seq_next_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            seq_in_d   = seq_in_q;
            step_idx_d = step_idx_q;
            captured_d = captured_q;
`ifdef SEQ_PLAYER_CHECK_EN
            err_count_d = err_count_q;
            pass_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            seq_in_q   <= 1'b0;
            seq_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_idx_q <= '0;
            captured_q <= '0;
`ifdef SEQ_PLAYER_CHECK_EN
            err_count_q <= '0;
            pass_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_in_q   <= seq_in_d;
            seq_next_q <= seq_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            step_idx_q <= step_idx_d;
            captured_q <= captured_d;
`ifdef SEQ_PLAYER_CHECK_EN
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
`endif
        end
    end

    assign seq_in   = seq_in_q;
    assign seq_next = seq_next_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_idx_q;
    assign captured = captured_q;

`ifdef SEQ_PLAYER_CHECK_EN
    assign err_count = err_count_q;
    assign pass      = pass_q;
`else
    logic unused_expect;
    assign unused_expect = ^EXPECT;
    assign err_count     = '0;
    assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: a default instance with driven out_fb and an echo instance
// whose out_fb follows its own seq_in.
module tb_seq_player;

    localparam int          LEN  = 11;
    localparam logic [10:0] PAT  = 11'h31A;
    localparam int          HIGH = 4;
    localparam int          P    = 9;
`ifdef SEQ_PLAYER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic fb = 1'b0;

    logic        seq_in, seq_next, busy, done, pass;
    logic [3:0]  step_idx, err_count;
    logic [10:0] captured;
    logic        e_seq_in, e_seq_next, e_busy, e_done, e_pass;
    logic [3:0]  e_step_idx, e_err_count;
    logic [10:0] e_captured;

    always #5 clk = ~clk;

    seq_player u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .out_fb(fb),
        .seq_in(seq_in), .seq_next(seq_next), .busy(busy), .done(done),
        .step_idx(step_idx), .captured(captured), .err_count(err_count), .pass(pass)
    );

    seq_player #(.EXPECT(11'h31A)) u_echo (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .out_fb(e_seq_in),
        .seq_in(e_seq_in), .seq_next(e_seq_next), .busy(e_busy), .done(e_done),
        .step_idx(e_step_idx), .captured(e_captured), .err_count(e_err_count), .pass(e_pass)
    );

    typedef struct packed {
        logic b;
        int   off;
        int   e0;
    } bit_t;

    typedef struct packed {
        logic [10:0] cap;
        logic [3:0]  err;
        logic        pass;
        int          e0;
    } res_t;

    bit_t q_bit[$];
    res_t q_res[$];
    res_t q_echo[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: press timing/bit order, press width, and end-of-run results for both instances.
    initial begin
        logic prev_next, prev_done, prev_edone;
        int   hi;
        bit_t it;
        res_t r;
        prev_next = 1'b0; prev_done = 1'b0; prev_edone = 1'b0; hi = 0;
        forever begin
            @(negedge clk);
            if (seq_next && !prev_next) begin
                check("press_expected", q_bit.size() > 0, 1);
                if (q_bit.size() > 0) begin
                    it = q_bit.pop_front();
                    check("press_seq_in", seq_in, it.b);
                    check("press_time", cyc - it.e0, it.off);
                end
                hi = 0;
            end
            if (seq_next) hi++;
            else if (prev_next && busy) check("press_width", hi, HIGH);
            if (done) begin
                check("done_single", prev_done, 0);
                check("done_expected", q_res.size() > 0, 1);
                if (q_res.size() > 0) begin
                    r = q_res.pop_front();
                    check("done_time", cyc - r.e0, LEN * P);
                    check("captured", captured, r.cap);
                    check("err_count", err_count, r.err);
                    check("pass", pass, r.pass);
                    check("busy_at_done", busy, 0);
                end
            end
            if (e_done) begin
                check("echo_done_expected", q_echo.size() > 0, 1);
                if (q_echo.size() > 0) begin
                    r = q_echo.pop_front();
                    check("echo_done_time", cyc - r.e0, LEN * P);
                    check("echo_captured", e_captured, r.cap);
                    check("echo_err_count", e_err_count, r.err);
                    check("echo_pass", e_pass, r.pass);
                end
            end
            prev_next  = seq_next;
            prev_done  = done;
            prev_edone = e_done;
        end
    end

    task automatic do_run(input logic fb_val, output int e0);
        @(negedge clk);
        fb    = fb_val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic push_bits(input int e0, input int nsteps);
        bit_t it;
        logic [10:0] sh;
        for (int k = 0; k < nsteps; k++) begin
            sh    = PAT >> k;
            it.b  = sh[0];
            it.off = k * P + 1;
            it.e0 = e0;
            q_bit.push_back(it);
        end
    endtask

    task automatic push_res(input logic [10:0] cap, input logic [3:0] err, input logic ps, input int e0);
        res_t r;
        r.cap = cap; r.err = err; r.pass = ps; r.e0 = e0;
        q_res.push_back(r);
    endtask

    task automatic push_echo(input int e0);
        res_t r;
        r.cap = PAT; r.err = 4'd0; r.pass = CHK; r.e0 = e0;
        q_echo.push_back(r);
    endtask

    task automatic wait_until(input int e0, input int off);
        for (int i = 0; i < 200 && (cyc - e0) < off; i++) @(negedge clk);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 120 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;

        repeat (3) @(negedge clk);
        check("rst_seq_next", seq_next, 0);
        check("rst_busy", busy, 0);
        check("rst_step_idx", step_idx, 0);
        check("rst_captured", captured, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of step 1's press.
        do_run(1'b1, e0);
        push_bits(e0, 2);
        wait_until(e0, 12);
        check("pre_rst_seq_next", seq_next, 1);
        check("pre_rst_step_idx", step_idx, 1);
        reset = 1'b0;
        #1;
        check("arst_seq_next", seq_next, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_seq_in", seq_in, 0);
        check("arst_step_idx", step_idx, 0);
        check("arst_captured", captured, 0);
        check("arst_err_count", err_count, 0);
        check("arst_pass", pass, 0);
        check("arst_echo_seq_next", e_seq_next, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_next", seq_next, 0);

        // Default playback with out_fb held low.
        do_run(1'b0, e0);
        push_bits(e0, LEN);
        push_res(11'h000, 4'd0, CHK, e0);
        push_echo(e0);
        wait_done();
        repeat (2) @(negedge clk);

        // out_fb held high against EXPECT = 0.
        do_run(1'b1, e0);
        push_bits(e0, LEN);
        push_res(11'h7FF, CHK ? 4'd11 : 4'd0, 1'b0, e0);
        push_echo(e0);
        wait_done();
        repeat (5) @(negedge clk);
        check("held_captured", captured, 11'h7FF);
        check("held_err_count", err_count, CHK ? 4'd11 : 4'd0);
        check("held_busy", busy, 0);
        check("held_echo_pass", e_pass, CHK);

        // Ignored start at E20, abort at E30 during step 3's press.
        do_run(1'b1, e0);
        push_bits(e0, 4);
        wait_until(e0, 19);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(e0, 29);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_seq_next", seq_next, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_step_idx", step_idx, 3);
        check("abort_captured", captured, 11'h007);
        check("abort_err_count", err_count, CHK ? 4'd3 : 4'd0);
        check("abort_pass", pass, 0);
        check("abort_echo_busy", e_busy, 0);
        repeat (20) @(negedge clk);

        // Full run after the abort.
        do_run(1'b0, e0);
        push_bits(e0, LEN);
        push_res(11'h000, 4'd0, CHK, e0);
        push_echo(e0);
        wait_done();
        repeat (3) @(negedge clk);

        check("leftover_presses", q_bit.size(), 0);
        check("leftover_results", q_res.size(), 0);
        check("leftover_echo", q_echo.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
